// File: rtl/quad_step_decoder.sv
// Quadrature input cleaner: synchronise, debounce, decode into step/dir/err, track position, drive a direction digit.
// Latency: a stable input level produces step on the (SYNC_STAGES+DEBOUNCE)th clock edge after it is first sampled.
// No backpressure: free-running, one decision per clock; outputs are registered pulses/levels.
module quad_step_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int POS_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic [POS_W-1:0] pos,
    output logic [6:0]       disp
);

    localparam int CNT_W = $clog2(DEBOUNCE) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    // Active-low segment patterns, bit0 = a .. bit6 = g
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_U    = 7'b1000001;
    localparam logic [6:0] SEG_D    = 7'b0100001;

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic                   a_s;
    logic                   b_s;

    logic                   a_f;
    logic                   b_f;
    logic [CNT_W-1:0]       a_cnt;
    logic [CNT_W-1:0]       b_cnt;
    logic [CNT_W-1:0]       a_cnt_nxt;
    logic [CNT_W-1:0]       b_cnt_nxt;
    logic                   a_load;
    logic                   b_load;
    logic                   a_f_nxt;
    logic                   b_f_nxt;

    logic                   fwd;
    logic                   rev;
    logic                   bad;
    logic                   seen;

    assign a_s = a_sync[SYNC_STAGES-1];
    assign b_s = b_sync[SYNC_STAGES-1];

    // Synchroniser chains for the two asynchronous channels
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], a_in};
            b_sync <= {b_sync[SYNC_STAGES-2:0], b_in};
        end
    end

    // Debounce: accept a new level only after it persists DEBOUNCE cycles
    always_comb begin
        a_load    = (a_s != a_f) && (a_cnt == CNT_MAX);
        b_load    = (b_s != b_f) && (b_cnt == CNT_MAX);
        a_cnt_nxt = ((a_s == a_f) || a_load) ? '0 : a_cnt + CNT_W'(1);
        b_cnt_nxt = ((b_s == b_f) || b_load) ? '0 : b_cnt + CNT_W'(1);
        a_f_nxt   = a_load ? a_s : a_f;
        b_f_nxt   = b_load ? b_s : b_f;
    end

    // Classify the old->new filtered pair along the Gray sequence 00,01,11,10
    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        bad = 1'b0;
        case ({a_f, b_f, a_f_nxt, b_f_nxt})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: rev = 1'b1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: bad = 1'b1;
            default: ;
        endcase
    end

    // Filtered state, debounce counters and decoded outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_cnt <= '0;
            b_cnt <= '0;
            a_f   <= 1'b0;
            b_f   <= 1'b0;
            step  <= 1'b0;
            err   <= 1'b0;
            dir   <= 1'b0;
            pos   <= '0;
            seen  <= 1'b0;
        end else begin
            a_cnt <= a_cnt_nxt;
            b_cnt <= b_cnt_nxt;
            a_f   <= a_f_nxt;
            b_f   <= b_f_nxt;
            step  <= fwd | rev;
            err   <= bad;
            if (fwd) begin
                dir  <= 1'b0;
                pos  <= pos + POS_W'(1);
                seen <= 1'b1;
            end else if (rev) begin
                dir  <= 1'b1;
                pos  <= pos - POS_W'(1);
                seen <= 1'b1;
            end
        end
    end

    // Digit follows the registered direction, so it lags the step pulse by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            disp <= SEG_DASH;
        end else if (!seen) begin
            disp <= SEG_DASH;
        end else begin
            disp <= dir ? SEG_D : SEG_U;
        end
    end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
Converts two raw, asynchronous quadrature inputs (rotary encoder or two-button pad) into clean step pulses plus a direction bit.
- Supplies the step and direction inputs that the lab's up/down counter consumes. dir polarity matches that counter: 1 = count down, 0 = count up.
- Keeps its own wrapping position count.
- Drives a 7-segment digit showing the last direction as U, d or '-'.

Parameters:
SYNC_STAGES, 2, flip-flop stages per input synchroniser (>=2)
DEBOUNCE, 4, consecutive cycles of a changed level required before it is accepted (>=1)
POS_W, 4, width of position counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
a_in  input  1  raw quadrature channel A, asynchronous
b_in  input  1  raw quadrature channel B, asynchronous
step  output  1  one-cycle pulse per valid quadrature transition
dir  output  1  direction of last valid step: 0 = up/forward, 1 = down/reverse
err  output  1  one-cycle pulse on an illegal transition (both channels changed)
pos  output  POS_W  position count, wraps modulo 2^POS_W
disp  output  7  active-low segments, bit0 = a .. bit6 = g

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - sync chains = 0, filtered a_f/b_f = 0, debounce counters = 0
  - step = 0, err = 0, dir = 0, pos = 0, seen = 0
  - disp = 7'b0111111 ('-')
- Reset applies mid-operation too; pending debounce counts are discarded.
- Synchroniser: each input passes SYNC_STAGES flops. Only the last stage (a_s/b_s) feeds later logic.
- Debounce, independent per channel, counter width ceil(log2(DEBOUNCE))+1:
  - If x_s == x_f: counter is cleared.
  - If x_s != x_f and counter < DEBOUNCE-1: counter increments.
  - If x_s != x_f and counter == DEBOUNCE-1: x_f <= x_s and counter cleared.
  - Any pulse shorter than DEBOUNCE cycles at the sync output is ignored.
- Decode: compares old {a_f,b_f} with the value being loaded, on the same edge that loads x_f.
  - Forward sequence 00->01->11->10->00: step=1, dir<=0, pos<=pos+1.
  - Reverse sequence 00->10->11->01->00: step=1, dir<=1, pos<=pos-1.
  - Both bits change on the same edge (00<->11, 01<->10): err=1, step=0. dir and pos unchanged; filtered state is still updated.
  - No change: step=0, err=0.
- step and err are registered pulses, high exactly one cycle, never high together.
- Latency: an input level held stable gives step high on the clock edge SYNC_STAGES+DEBOUNCE after the first edge that samples it. Defaults: 6 cycles.
- pos arithmetic is modulo 2^POS_W:
  - max + 1 -> 0
  - 0 - 1 -> max
- disp is registered:
  - '-' = 7'b0111111 until the first valid step (seen=0).
  - After the first valid step: dir=0 -> 'U' = 7'b1000001; dir=1 -> 'd' = 7'b0100001.
  - Updates one cycle after the step pulse.
  - err does not change disp.

Test Plan:
- Reset: hold rst 3 cycles with a_in=b_in=1 -> step=0, err=0, pos=0, dir=0, disp=7'b0111111. After release, filtered state goes to 11 after debounce; that is an illegal 00->11 jump, so exactly one err pulse and pos stays 0.
- Forward: from 00, drive AB 01,11,10,00, each held 10 cycles (defaults) -> 4 step pulses, each 6 cycles after its input change; dir=0; pos 0->4; disp=7'b1000001.
- Reverse with wrap: from pos=0, drive AB 10,11,01 -> 3 steps, dir=1, pos=13 (4'hD), disp=7'b0100001.
- Bounce rejection: toggle a_in for 3-cycle glitches 5 times, then hold stable -> only one step pulse, after the final stable level.
- Illegal jump: from 00, change a_in and b_in on the same cycle to 11 -> err pulse of exactly 1 cycle, step=0, pos and dir unchanged.
- Reset mid-debounce: change a_in, assert rst 2 cycles later for 1 cycle, then release -> no step, pos=0, disp='-'. If a_in is still 1, a step appears 6 cycles after release.
